serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Serial bit-sequence transmitter. It is the driving end for the team's serial sequence-detector FSMs, which sample one bit `w` per clock. A WIDTH-bit pattern is loaded on `start` and shifted out MSB-first, one bit per clock. The pattern can be sent several times, with optional idle-zero gap cycles between copies. A one-cycle `done` pulse marks the end of the transmission. The block is used as the stimulus source and loop-back partner for the detector labs.

Parameters:
WIDTH, 8, pattern length in bits (minimum 2)
GAP, 2, number of w=0 cycles inserted between repeats (0 allowed)
REP_W, 4, width of the repeat-count input

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  request to transmit; sampled only in IDLE
pattern  input  WIDTH  bits to send, MSB first; captured when start is accepted
repeats  input  REP_W  number of copies to send; 0 is treated as 1
abort  input  1  synchronous cancel, highest priority after reset
w  output  1  serial data bit (registered)
busy  output  1  high from start acceptance until the DONE state is entered
done  output  1  one-cycle pulse after the last bit of the last copy
presentState  output  2  current FSM state: IDLE=0, SHIFT=1, GAP=2, DONE=3
bit_cnt  output  log2(WIDTH)+1  index of the bit currently on w within the copy (0 = MSB)

Behaviour:
- Reset (reset==0, any time, asynchronous):
  - presentState=IDLE, w=0, busy=0, done=0, bit_cnt=0.
  - Internal shift register and repeat counter cleared.
  - Reset mid-transmission drops w to 0 immediately; no done pulse.
- All other state updates happen on the rising edge of clock. All outputs are registered.
- IDLE: w=0, busy=0.
  - If start==1 at the edge: capture pattern, load rep_left=max(repeats,1), set bit_cnt=0, go to SHIFT.
  - On that same edge w<=pattern[WIDTH-1] and busy<=1. So the first bit is valid in the cycle immediately after start is sampled (latency 1).
- SHIFT: each edge advances to the next bit and increments bit_cnt.
  - After bit WIDTH-1 has been on w for one cycle, the next edge acts as follows:
  - rep_left>1 and GAP>0: go to GAP, w<=0, decrement rep_left.
  - rep_left>1 and GAP==0: reload the captured pattern, w<=MSB, bit_cnt<=0, decrement rep_left, stay in SHIFT. Copies are back-to-back with no bubble.
  - rep_left==1: go to DONE, w<=0, busy<=0, done<=1.
- GAP: hold w=0 for exactly GAP cycles, counted by an internal gap counter.
  - Then reload the pattern, w<=MSB, bit_cnt<=0, go to SHIFT.
  - busy stays 1 throughout.
- DONE: done=1 for exactly one cycle, w=0. Unconditionally go to IDLE on the next edge.
  - start in DONE is ignored. start is accepted no earlier than the first IDLE cycle.
- start while busy (SHIFT/GAP/DONE) is ignored. pattern and repeats changes while busy have no effect.
- abort==1 at an edge in any non-IDLE state: go to IDLE, w<=0, busy<=0, bit_cnt<=0, done stays 0.
  - abort has priority over start in IDLE, so start is not accepted that edge.
- Total transmission length from start edge to the done pulse: R*WIDTH + (R-1)*GAP cycles of data/gap, where R=max(repeats,1), then one DONE cycle.
- The unused state encoding (none for 2 bits) and any illegal internal counter value recover to IDLE.

Test Plan:
1. Reset low, then high; start=1 for 1 cycle with pattern=8'b1011_0110, repeats=1 -> w=1,0,1,1,0,1,1,0 in cycles 1..8 after the start edge; bit_cnt=0..7; done=1 in cycle 9 only; busy high in cycles 1..8.
2. pattern=8'b1100_0001, repeats=2, GAP=2 -> w=1,1,0,0,0,0,0,1, then 0,0 (GAP state), then 1,1,0,0,0,0,0,1; done in cycle 19; busy low in cycle 19.
3. repeats=0, pattern=8'hFF -> identical to repeats=1: eight 1s, then done. Rerun with GAP=0 and repeats=3 -> 24 consecutive 1s, no zero bubble, done in cycle 25.
4. Start a transmission, then pulse start again in cycle 3 with pattern=8'h00 -> ignored; the original pattern completes unchanged with exactly one done pulse.
5. Drive reset low asynchronously between clock edges during cycle 4 of SHIFT -> w, busy and done are 0 before the next edge; presentState=IDLE. After release, a new start transmits correctly from the MSB.
6. abort=1 in GAP cycle 1 of a repeats=3 run -> next edge: presentState=IDLE, w=0, busy=0, no done pulse. start on that same edge is not accepted; start one cycle later is accepted.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first, optionally repeated with zero gaps.
// Latency: first bit on w the cycle after start is sampled; done pulses one cycle after the last bit of the last copy.
// Backpressure: none; start is only honoured in IDLE, and abort cancels any transmission in progress.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int REP_W = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeats,
  input  logic             abort,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       presentState,
  output logic [CNT_W-1:0] bit_cnt
);

  // Gap counter counts down from GAP-1 to 0; keep it at least one bit wide even when GAP is 0.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;   // captured copy used for every repeat
  logic [WIDTH-1:0] sh_q, sh_d;     // bits still to send in the current copy, MSB next
  logic [REP_W-1:0] rep_q, rep_d;   // copies remaining, including the one in flight
  logic [GAP_W-1:0] gap_q, gap_d;   // gap cycles remaining after the current one
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers; reset forces everything quiet immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; w and done default low so only SHIFT/DONE raise them.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          // abort also blocks acceptance here so a cancel and a new request never collide
          if (start && !abort) begin
            pat_d   = pattern;
            w_d     = pattern[WIDTH-1];
            sh_d    = {pattern[WIDTH-2:0], 1'b0};
            rep_d   = (repeats == '0) ? REP_ONE : repeats;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_SHIFT;
          end
        end

        S_SHIFT: begin
          if ((cnt_q > LAST_BIT) || (rep_q == '0)) begin
            // corrupted counters: abandon the transfer rather than emit garbage
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q != LAST_BIT) begin
            w_d   = sh_q[WIDTH-1];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_ONE;
          end else if (rep_q > REP_ONE) begin
            rep_d = rep_q - REP_ONE;
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
              cnt_d   = '0;
            end else begin
              // back-to-back copy: MSB follows the LSB with no bubble
              w_d   = pat_q[WIDTH-1];
              sh_d  = {pat_q[WIDTH-2:0], 1'b0};
              cnt_d = '0;
            end
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end

        S_GAP: begin
          if ((gap_q > GAP_LOAD) || (rep_q == '0)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else if (gap_q == '0) begin
            w_d     = pat_q[WIDTH-1];
            sh_d    = {pat_q[WIDTH-2:0], 1'b0};
            cnt_d   = '0;
            state_d = S_SHIFT;
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end

        S_DONE: begin
          // done lasts exactly one cycle; start here is deliberately ignored
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign w            = w_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign presentState = state_q;
  assign bit_cnt      = cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP=2 and GAP=0) share one stimulus stream.
// Latency: outputs sampled on the falling edge, i.e. half a cycle after the edge that produced them.
// Backpressure: none; expected waveforms come from an arithmetic timeline model per instance.
module tb_serial_pattern_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] repeats;
  logic       abort;

  logic       w_o    [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [1:0] st_o   [2];
  logic [3:0] bc_o   [2];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  serial_pattern_tx #(.WIDTH(8), .GAP(2), .REP_W(4)) u_gap2 (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern),
    .repeats(repeats), .abort(abort), .w(w_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .presentState(st_o[0]), .bit_cnt(bc_o[0])
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0), .REP_W(4)) u_gap0 (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern),
    .repeats(repeats), .abort(abort), .w(w_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .presentState(st_o[1]), .bit_cnt(bc_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       w;
    logic       busy;
    logic       done;
    logic [1:0] st;
    logic [3:0] bc;
  } exp_t;

  // Model state: cycle index t since the accepting edge (t=1 is the first bit).
  bit         m_act [2];
  int         m_t   [2];
  logic [7:0] m_pat [2];
  int         m_r   [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int total_of(input int r, input int gap);
    return r * 8 + (r - 1) * gap;
  endfunction

  // Expected outputs for cycle t of a transmission: copies of 8 bits separated by gap zeros, then one DONE cycle.
  function automatic exp_t model_out(input bit act, input int t, input logic [7:0] pat,
                                     input int r, input int gap);
    exp_t e;
    int   k;
    e = '0;
    if (act) begin
      if (t <= total_of(r, gap)) begin
        e.busy = 1'b1;
        k = (t - 1) % (8 + gap);
        if (k < 8) begin
          e.w  = pat[7-k];
          e.st = 2'd1;
          e.bc = 4'(k);
        end else begin
          e.st = 2'd2;
        end
      end else if (t == total_of(r, gap) + 1) begin
        e.done = 1'b1;
        e.st   = 2'd3;
      end
    end
    return e;
  endfunction

  // Advance each instance's timeline on the active edge.
  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_act[k] <= 1'b0;
        m_t[k]   <= 0;
      end else if (m_act[k]) begin
        if (abort) m_act[k] <= 1'b0;
        else if (m_t[k] >= total_of(m_r[k], gap_of(k)) + 1) m_act[k] <= 1'b0;
        else m_t[k] <= m_t[k] + 1;
      end else if (start && !abort) begin
        m_act[k] <= 1'b1;
        m_t[k]   <= 1;
        m_pat[k] <= pattern;
        m_r[k]   <= (repeats == 4'd0) ? 1 : int'(repeats);
      end
    end
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Compare every instance against the model once per cycle.
  always @(negedge clock) begin
    exp_t e;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e = model_out(m_act[k], m_t[k], m_pat[k], m_r[k], gap_of(k));
        chk("w", k, int'(w_o[k]), int'(e.w));
        chk("busy", k, int'(busy_o[k]), int'(e.busy));
        chk("done", k, int'(done_o[k]), int'(e.done));
        chk("state", k, int'(st_o[k]), int'(e.st));
        if (e.st == 2'd1) chk("bit_cnt", k, int'(bc_o[k]), int'(e.bc));
      end
    end
  end

  task automatic step(input logic st, input logic [7:0] pat, input logic [3:0] rep, input logic ab);
    @(negedge clock);
    start   = st;
    pattern = pat;
    repeats = rep;
    abort   = ab;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  initial begin
    logic [7:0]  cap8;
    logic [17:0] cap18;
    int          done_at;
    int          ones;
    int          pulses;

    reset = 1'b0; start = 1'b0; pattern = '0; repeats = '0; abort = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_w", k, int'(w_o[k]), 0);
      chk("rst_busy", k, int'(busy_o[k]), 0);
      chk("rst_done", k, int'(done_o[k]), 0);
      chk("rst_state", k, int'(st_o[k]), 0);
      chk("rst_bit_cnt", k, int'(bc_o[k]), 0);
    end
    reset  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Single copy of 1011_0110.
    step(1'b1, 8'b1011_0110, 4'd1, 1'b0);
    cap8 = '0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      idle(1);
      if (c <= 8) cap8 = {cap8[6:0], w_o[0]};
      if (done_o[0] && done_at == 0) done_at = c;
    end
    chk("t1_stream", 0, int'(cap8), 8'hB6);
    chk("t1_done_cycle", 0, done_at, 9);

    // Two copies with a two-cycle gap.
    step(1'b1, 8'b1100_0001, 4'd2, 1'b0);
    cap18 = '0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      idle(1);
      if (c <= 18) cap18 = {cap18[16:0], w_o[0]};
      if (done_o[0] && done_at == 0) begin
        done_at = c;
        chk("t2_busy_at_done", 0, int'(busy_o[0]), 0);
      end
    end
    chk("t2_stream", 0, int'(cap18), 18'b11000001_00_11000001);
    chk("t2_done_cycle", 0, done_at, 19);

    // repeats=0 behaves as one copy.
    step(1'b1, 8'hFF, 4'd0, 1'b0);
    ones = 0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      idle(1);
      if (w_o[0]) ones++;
      if (done_o[0] && done_at == 0) done_at = c;
    end
    chk("t3_ones", 0, ones, 8);
    chk("t3_done_cycle", 0, done_at, 9);

    // GAP=0 instance: three copies back-to-back.
    step(1'b1, 8'hFF, 4'd3, 1'b0);
    ones = 0; done_at = 0;
    for (int c = 1; c <= 31; c++) begin
      idle(1);
      if (c <= 24 && w_o[1]) ones++;
      if (done_o[1] && done_at == 0) done_at = c;
    end
    chk("t3b_ones", 1, ones, 24);
    chk("t3b_done_cycle", 1, done_at, 25);
    idle(2);

    // A second start while busy is ignored.
    step(1'b1, 8'hA5, 4'd1, 1'b0);
    cap8 = '0; pulses = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 3) step(1'b1, 8'h00, 4'd7, 1'b0);
      else idle(1);
      if (c <= 8) cap8 = {cap8[6:0], w_o[0]};
      if (done_o[0]) pulses++;
    end
    chk("t4_stream", 0, int'(cap8), 8'hA5);
    chk("t4_done_pulses", 0, pulses, 1);

    // Asynchronous reset in the middle of a copy.
    step(1'b1, 8'h3C, 4'd1, 1'b0);
    idle(4);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_async_w", k, int'(w_o[k]), 0);
      chk("t5_async_busy", k, int'(busy_o[k]), 0);
      chk("t5_async_done", k, int'(done_o[k]), 0);
      chk("t5_async_state", k, int'(st_o[k]), 0);
    end
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 8'h96, 4'd1, 1'b0);
    cap8 = '0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      idle(1);
      if (c <= 8) cap8 = {cap8[6:0], w_o[0]};
      if (done_o[0] && done_at == 0) done_at = c;
    end
    chk("t5_stream", 0, int'(cap8), 8'h96);
    chk("t5_done_cycle", 0, done_at, 9);

    // Abort during the first gap cycle; start on the abort edge is dropped, the next one is taken.
    step(1'b1, 8'hE7, 4'd3, 1'b0);
    idle(8);
    step(1'b1, 8'h00, 4'd1, 1'b1);
    chk("t6_in_gap", 0, int'(st_o[0]), 2);
    chk("t6_gap_w", 0, int'(w_o[0]), 0);
    step(1'b1, 8'h5A, 4'd1, 1'b0);
    chk("t6_abort_state", 0, int'(st_o[0]), 0);
    chk("t6_abort_busy", 0, int'(busy_o[0]), 0);
    chk("t6_abort_done", 0, int'(done_o[0]), 0);
    idle(1);
    chk("t6_restart_state", 0, int'(st_o[0]), 1);
    chk("t6_restart_busy", 0, int'(busy_o[0]), 1);
    chk("t6_restart_w", 0, int'(w_o[0]), 0);
    idle(1);
    chk("t6_restart_w2", 0, int'(w_o[0]), 1);
    idle(12);

    // Randomized traffic: starts at random times, random repeat counts, occasional aborts.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 4) == 0), 8'($urandom), 4'($urandom_range(0, 4)),
           1'($urandom_range(0, 45) == 0));
    end
    idle(60);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
